video_mode_loader: RTL and testbench

//   Mode-set sequencer and bus arbiter in front of the Video register block.
//   On iStart, walks a per-mode table of port accesses and issues each one as
//   a single-cycle Video bus strobe, waiting for its ack before issuing the next.

---
 rtl/video_mode_loader_if.sv | 30 +++
 rtl/video_mode_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_video_mode_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_mode_loader_if.sv
// Port-access bus used on both sides of the video mode loader.
//   rw     : strobe, [1]=read, [0]=write, one-cycle pulse
//   adr    : 7-bit port address
//   wrData : write data
//   rdData : read data, valid with ack
//   ack    : one-cycle acknowledge
// The master issues strobes; the slave returns rdData/ack.
interface video_mode_loader_if;
    logic [1:0] rw;
    logic [6:0] adr;
    logic [7:0] wrData;
    logic [7:0] rdData;
    logic       ack;

    modport master (
        output rw,
        output adr,
        output wrData,
        input  rdData,
        input  ack
    );

    modport slave (
        input  rw,
        input  adr,
        input  wrData,
        output rdData,
        output ack
    );
endinterface

// File: rtl/video_mode_loader.sv
// Mode-set sequencer and bus arbiter in front of the Video register block.
// On iStart it walks the table entries of the chosen mode, issuing each as a
// one-cycle Video strobe and waiting for its ack. While idle the CPU port is
// passed straight through to the Video bus; CPU accesses made during a load
// are parked in a one-deep slot and issued when the load finishes.
// Ports:
//   iClk, iRstN     clock, asynchronous active-low reset
//   iStart, iMode   start request and mode (sampled only when idle)
//   oBusy           load in progress
//   oDone           one-cycle pulse when a load ends without error
//   oErr            sticky ack timeout, cleared by the next accepted iStart
//   oCpuOvf         sticky dropped CPU request, cleared by the next accepted iStart
//   oTabAdr         table ROM address {mode, step}
//   iTabData        table entry [16]=END [15]=READ [14:8]=adr [7:0]=data
//   cpu             CPU-facing bus (this block is the slave)
//   vid             Video-facing bus (this block is the master)
module video_mode_loader #(
    parameter int unsigned STEPS       = 64,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    input  logic                       iStart,
    input  logic [1:0]                 iMode,
    output logic                       oBusy,
    output logic                       oDone,
    output logic                       oErr,
    output logic                       oCpuOvf,
    output logic [7:0]                 oTabAdr,
    input  logic [16:0]                iTabData,
    video_mode_loader_if.slave         cpu,
    video_mode_loader_if.master        vid
);

    localparam logic [5:0] LastStep  = 6'(STEPS - 1);
    localparam logic [3:0] TimerLoad = 4'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StFlush,
        StFlushWait
    } stateT;

    stateT      stateQ, stateD;
    logic [1:0] modeQ;
    logic [5:0] stepQ;
    logic [3:0] timerQ;
    logic       entEndQ;
    logic       slotFullQ;
    logic [1:0] slotRwQ;
    logic [6:0] slotAdrQ;
    logic [7:0] slotDataQ;
    logic       cpuOutQ;
    logic       errQ;
    logic       ovfQ;
    logic       doneQ;

    logic       timeout;
    logic       lastEntry;
    logic       loadPhase;
    logic       cpuStrobe;

    assign timeout   = (timerQ == 4'd1) && !vid.ack;
    assign lastEntry = entEndQ || (stepQ == LastStep);
    assign loadPhase = (stateQ == StFetch) || (stateQ == StIssue) || (stateQ == StWait);
    assign cpuStrobe = |cpu.rw;

    // State register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (iStart) begin
                    stateD = StFetch;
                end
            end
            StFetch: stateD = StIssue;
            StIssue: stateD = StWait;
            StWait: begin
                if (vid.ack) begin
                    stateD = lastEntry ? StFlush : StFetch;
                end else if (timeout) begin
                    stateD = StFlush;
                end
            end
            StFlush: begin
                stateD = slotFullQ ? StFlushWait : StIdle;
            end
            StFlushWait: begin
                if (vid.ack || timeout) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        vid.rw     = 2'b00;
        vid.adr    = 7'd0;
        vid.wrData = 8'd0;
        cpu.rdData = 8'd0;
        cpu.ack    = 1'b0;
        unique case (stateQ)
            StIdle: begin
                vid.rw     = cpu.rw;
                vid.adr    = cpu.adr;
                vid.wrData = cpu.wrData;
                cpu.rdData = vid.rdData;
                cpu.ack    = vid.ack;
            end
            StFetch: begin
                // Ack of a CPU access that went out alongside the accepted iStart
                if (cpuOutQ) begin
                    cpu.rdData = vid.rdData;
                    cpu.ack    = vid.ack;
                end
            end
            StIssue: begin
                vid.rw     = iTabData[15] ? 2'b10 : 2'b01;
                vid.adr    = iTabData[14:8];
                vid.wrData = iTabData[7:0];
            end
            StWait: begin
            end
            StFlush: begin
                if (slotFullQ) begin
                    vid.rw     = slotRwQ;
                    vid.adr    = slotAdrQ;
                    vid.wrData = slotDataQ;
                end
            end
            StFlushWait: begin
                if (vid.ack) begin
                    cpu.rdData = vid.rdData;
                    cpu.ack    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign oBusy   = (stateQ != StIdle);
    assign oDone   = doneQ;
    assign oErr    = errQ;
    assign oCpuOvf = ovfQ;
    assign oTabAdr = {modeQ, stepQ};

    // Datapath: step/timer, pending slot, sticky flags
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            modeQ     <= 2'd0;
            stepQ     <= 6'd0;
            timerQ    <= 4'd0;
            entEndQ   <= 1'b0;
            slotFullQ <= 1'b0;
            slotRwQ   <= 2'b00;
            slotAdrQ  <= 7'd0;
            slotDataQ <= 8'd0;
            cpuOutQ   <= 1'b0;
            errQ      <= 1'b0;
            ovfQ      <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ   <= 1'b0;
            cpuOutQ <= (stateQ == StIdle) && cpuStrobe;

            // Slot accepts only during the table walk; once flushing has begun a
            // new request could not be issued before returning to idle.
            if ((stateQ != StIdle) && cpuStrobe) begin
                if (loadPhase && !slotFullQ) begin
                    slotFullQ <= 1'b1;
                    slotRwQ   <= cpu.rw;
                    slotAdrQ  <= cpu.adr;
                    slotDataQ <= cpu.wrData;
                end else begin
                    ovfQ <= 1'b1;
                end
            end

            unique case (stateQ)
                StIdle: begin
                    if (iStart) begin
                        modeQ <= iMode;
                        stepQ <= 6'd0;
                        errQ  <= 1'b0;
                        ovfQ  <= 1'b0;
                    end
                end
                StFetch: begin
                end
                StIssue: begin
                    timerQ  <= TimerLoad;
                    entEndQ <= iTabData[16];
                end
                StWait: begin
                    if (vid.ack) begin
                        if (!lastEntry) begin
                            stepQ <= stepQ + 6'd1;
                        end
                    end else if (timeout) begin
                        errQ <= 1'b1;
                    end else begin
                        timerQ <= timerQ - 4'd1;
                    end
                end
                StFlush: begin
                    if (slotFullQ) begin
                        timerQ <= TimerLoad;
                    end else begin
                        doneQ <= !errQ;
                    end
                end
                StFlushWait: begin
                    if (vid.ack) begin
                        slotFullQ <= 1'b0;
                        doneQ     <= !errQ;
                    end else if (timeout) begin
                        slotFullQ <= 1'b0;
                        errQ      <= 1'b1;
                    end else begin
                        timerQ <= timerQ - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_mode_loader.sv
module tb_video_mode_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [1:0]  mode;
    logic        busy, done, err, ovf;
    logic [7:0]  tabAdr;
    logic [16:0] tabData;

    video_mode_loader_if cpuBus();
    video_mode_loader_if vidBus();

    always #5 clk = ~clk;

    video_mode_loader #(.STEPS(64), .ACK_TIMEOUT(15)) dut (
        .iClk     (clk),
        .iRstN    (rstN),
        .iStart   (start),
        .iMode    (mode),
        .oBusy    (busy),
        .oDone    (done),
        .oErr     (err),
        .oCpuOvf  (ovf),
        .oTabAdr  (tabAdr),
        .iTabData (tabData),
        .cpu      (cpuBus.slave),
        .vid      (vidBus.master)
    );

    // Table ROM, one-cycle read latency
    logic [16:0] tab [256];
    always @(posedge clk) tabData <= tab[tabAdr];

    // Video register stub: ack one cycle after strobe, reads return adr^0x3C.
    // Port 0x40 models the attribute-controller index/data flip-flop; reading
    // 0x5A resets it.
    logic       ackEn;
    logic [7:0] regs [128];
    logic [7:0] ac [32];
    logic       acFf;
    logic [4:0] acIdx;
    always @(posedge clk) begin
        if (!rstN) begin
            vidBus.ack    <= 1'b0;
            vidBus.rdData <= 8'd0;
            acFf          <= 1'b0;
        end else begin
            vidBus.ack <= 1'b0;
            if (vidBus.rw != 2'b00 && ackEn) begin
                vidBus.ack <= 1'b1;
                if (vidBus.rw[1]) begin
                    vidBus.rdData <= {1'b0, vidBus.adr} ^ 8'h3C;
                    if (vidBus.adr == 7'h5A) acFf <= 1'b0;
                end else begin
                    regs[vidBus.adr] <= vidBus.wrData;
                    if (vidBus.adr == 7'h40) begin
                        if (!acFf) acIdx <= vidBus.wrData[4:0];
                        else ac[acIdx] <= vidBus.wrData;
                        acFf <= ~acFf;
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0] rw;
        logic [6:0] adr;
        logic [7:0] data;
    } strobeT;

    typedef struct packed {
        logic       isRead;
        logic [7:0] data;
    } ackT;

    strobeT vidQ[$];
    ackT    cpuQ[$];
    strobeT monE;
    ackT    monA;
    int     compared = 0;
    int     mismatched = 0;
    int     doneCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every Video strobe and CPU ack is matched against the scoreboard
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (vidBus.rw != 2'b00) begin
                if (vidQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL vid_strobe: unexpected rw=%b adr=%h data=%h, want none",
                             vidBus.rw, vidBus.adr, vidBus.wrData);
                end else begin
                    monE = vidQ.pop_front();
                    check("vid_strobe", 32'({vidBus.rw, vidBus.adr, vidBus.wrData}), 32'(monE));
                end
            end
            if (cpuBus.ack) begin
                if (cpuQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL cpu_ack: unexpected ack data=%h, want none", cpuBus.rdData);
                end else begin
                    monA = cpuQ.pop_front();
                    if (monA.isRead) check("cpu_rd_data", 32'(cpuBus.rdData), 32'(monA.data));
                end
            end
            if (done) doneCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected strobes of one table walk, derived from the bench's own table
    task automatic pushMode(input logic [1:0] m);
        logic [16:0] ent;
        logic [5:0]  s;
        for (int i = 0; i < 64; i++) begin
            s   = 6'(i);
            ent = tab[{m, s}];
            vidQ.push_back({(ent[15] ? 2'b10 : 2'b01), ent[14:8], ent[7:0]});
            if (ent[16]) break;
        end
    endtask

    task automatic startLoad(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        pushMode(m);
        tick();
        start = 1'b0;
    endtask

    task automatic cpuStrobe(input logic [1:0] rw, input logic [6:0] adr, input logic [7:0] d);
        cpuBus.rw     = rw;
        cpuBus.adr    = adr;
        cpuBus.wrData = d;
        tick();
        cpuBus.rw     = 2'b00;
        cpuBus.adr    = 7'd0;
        cpuBus.wrData = 8'd0;
    endtask

    task automatic waitIdle(output int cycles);
        bit fin;
        fin    = 1'b0;
        cycles = 0;
        for (int k = 0; k < 1000 && !fin; k++) begin
            @(negedge clk);
            if (!busy) fin = 1'b1;
            else cycles++;
        end
        if (!fin) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle: still busy after 1000 cycles, want idle");
        end
    endtask

    int cyc;
    int d0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        rstN          = 1'b0;
        start         = 1'b0;
        mode          = 2'd0;
        ackEn         = 1'b1;
        cpuBus.rw     = 2'b00;
        cpuBus.adr    = 7'd0;
        cpuBus.wrData = 8'd0;
        for (int i = 0; i < 256; i++) tab[i] = 17'h10000;
        for (int i = 0; i < 64; i++) tab[i] = {2'b00, 7'(i), 8'(i) ^ 8'h5A};
        tab[8'h40] = {2'b00, 7'h44, 8'h02};
        tab[8'h41] = {2'b00, 7'h45, 8'h0F};
        tab[8'h42] = {2'b10, 7'h42, 8'h63};
        tab[8'h80] = {2'b01, 7'h5A, 8'h00};
        tab[8'h81] = {2'b00, 7'h40, 8'h10};
        tab[8'h82] = {2'b10, 7'h40, 8'h41};
        tab[8'hC0] = {2'b10, 7'h41, 8'h00};

        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_tabadr", 32'(tabAdr), 0);
        check("rst_vidrw", 32'(vidBus.rw), 0);
        rstN = 1'b1;
        tick();

        // 1: three writes, three cycles each plus the flush cycle
        d0 = doneCount;
        startLoad(2'd1);
        waitIdle(cyc);
        check("t1_busy_cycles", 32'(cyc), 10);
        tick();
        check("t1_done_pulses", 32'(doneCount - d0), 1);
        check("t1_done_low", 32'(done), 0);
        check("t1_reg42", 32'(regs[7'h42]), 32'h63);

        // 2: read then AC index/data writes
        d0 = doneCount;
        startLoad(2'd2);
        waitIdle(cyc);
        tick();
        check("t2_ac10", 32'(ac[5'h10]), 32'h41);
        check("t2_done_pulses", 32'(doneCount - d0), 1);

        // 3: CPU write held during load, second strobe overflows
        d0 = doneCount;
        startLoad(2'd2);
        tick();
        vidQ.push_back({2'b01, 7'h54, 8'h0C});
        cpuQ.push_back({1'b0, 8'h00});
        cpuStrobe(2'b01, 7'h54, 8'h0C);
        tick();
        cpuStrobe(2'b01, 7'h55, 8'h77);
        waitIdle(cyc);
        check("t3_ovf", 32'(ovf), 1);
        tick();
        check("t3_reg54", 32'(regs[7'h54]), 32'h0C);
        check("t3_done_pulses", 32'(doneCount - d0), 1);
        check("t3_cpuq_empty", 32'(cpuQ.size()), 0);

        // 4: no ack -> timeout after 15 WAIT cycles, then next start clears oErr
        d0 = doneCount;
        ackEn = 1'b0;
        startLoad(2'd3);
        waitIdle(cyc);
        check("t4_busy_cycles", 32'(cyc), 18);
        check("t4_err", 32'(err), 1);
        check("t4_ovf_cleared", 32'(ovf), 0);
        tick();
        check("t4_no_done", 32'(doneCount - d0), 0);
        ackEn = 1'b1;
        d0 = doneCount;
        startLoad(2'd1);
        check("t4_err_cleared", 32'(err), 0);
        waitIdle(cyc);
        tick();
        check("t4_done_after", 32'(doneCount - d0), 1);

        // 5: idle CPU read passthrough, then alongside iStart
        vidQ.push_back({2'b10, 7'h4F, 8'h00});
        cpuQ.push_back({1'b1, 8'h4F ^ 8'h3C});
        cpuBus.rw  = 2'b10;
        cpuBus.adr = 7'h4F;
        #1;
        check("t5_passthru_rw", 32'(vidBus.rw), 32'h2);
        check("t5_passthru_adr", 32'(vidBus.adr), 32'h4F);
        tick();
        cpuBus.rw  = 2'b00;
        cpuBus.adr = 7'd0;
        repeat (2) tick();
        check("t5_idle_ack_seen", 32'(cpuQ.size()), 0);
        d0 = doneCount;
        vidQ.push_back({2'b10, 7'h4F, 8'h00});
        cpuQ.push_back({1'b1, 8'h4F ^ 8'h3C});
        cpuBus.rw  = 2'b10;
        cpuBus.adr = 7'h4F;
        startLoad(2'd1);
        cpuBus.rw  = 2'b00;
        cpuBus.adr = 7'd0;
        waitIdle(cyc);
        tick();
        check("t5_start_ack_seen", 32'(cpuQ.size()), 0);
        check("t5_done_pulses", 32'(doneCount - d0), 1);

        // 6: reset during WAIT, then a 64-entry table without END
        ackEn = 1'b0;
        startLoad(2'd3);
        repeat (4) tick();
        rstN = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_vidrw", 32'(vidBus.rw), 0);
        check("t6_rst_tabadr", 32'(tabAdr), 0);
        check("t6_rst_cpuack", 32'(cpuBus.ack), 0);
        tick();
        rstN  = 1'b1;
        ackEn = 1'b1;
        tick();
        d0 = doneCount;
        startLoad(2'd0);
        waitIdle(cyc);
        check("t6_busy_cycles", 32'(cyc), 193);
        tick();
        check("t6_done_pulses", 32'(doneCount - d0), 1);
        repeat (3) tick();
        check("end_vidq_empty", 32'(vidQ.size()), 0);
        check("end_cpuq_empty", 32'(cpuQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
